nzcv_status_reg: RTL and testbench
==================================

Name: nzcv_status_reg

Overview:
- Architectural status register that sits directly downstream of the ALU flag generator.
- Captures the generator's combinational {N,Z,C,V} output on flag-setting instructions and holds it across non-flag-setting instructions.
- Evaluates the 4-bit condition field of the next instruction against the held flags for conditional execution.
- Provides a small LIFO of saved flag sets for interrupt/exception entry and return.

Parameters:
- DEPTH, 4, number of entries in the flag save stack (power of 2, minimum 2).
- BYPASS, 1, when 1 cond_pass evaluates the flags being written this cycle; when 0 it evaluates the registered flags only.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- flags_in  input  4  {N,Z,C,V} from the ALU flag generator.
- s_bit  input  1  S bit of the instruction currently in execute.
- opcode  input  4  opcode of the instruction currently in execute.
- stall  input  1  execute stage stalled; suppresses flag capture.
- cond  input  4  condition field of the instruction being issued.
- push  input  1  save current flags (interrupt entry).
- pop  input  1  restore flags from stack (interrupt return).
- nzcv  output  4  registered flags {N,Z,C,V}.
- cond_pass  output  1  condition satisfied (combinational).
- stack_depth  output  clog2(DEPTH)+1  number of valid stack entries.
- stack_full  output  1  stack_depth == DEPTH.
- stack_empty  output  1  stack_depth == 0.
- stack_err  output  1  one-cycle pulse on an illegal stack operation.

Behaviour:
- Reset (asynchronous, rst_n low): nzcv=4'b0000, stack_depth=0, stack_err=0, stack contents cleared to 0.
  - Reset asserted mid-sequence discards all saved entries immediately.
- Capture enable: upd = s_bit & (opcode != 4'b1111) & ~stall.
  - On a rising edge with upd=1: nzcv <= flags_in.
  - Otherwise nzcv holds. Capture latency is 1 cycle.
  - CMP (opcode 4'b1000) needs no special handling: flags_in already carries the result.
- Effective flags for evaluation: eff = (BYPASS && upd) ? flags_in : nzcv.
- cond_pass is decoded from eff with N=eff[3], Z=eff[2], C=eff[1], V=eff[0]:
  - 0000 EQ Z
  - 0001 NE !Z
  - 0010 CS C
  - 0011 CC !C
  - 0100 MI N
  - 0101 PL !N
  - 0110 VS V
  - 0111 VC !V
  - 1000 HI C&!Z
  - 1001 LS !C|Z
  - 1010 GE N==V
  - 1011 LT N!=V
  - 1100 GT !Z&(N==V)
  - 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111 NV 0
- Stack:
  - Push: writes nzcv (the pre-update value) to entry[stack_depth]; stack_depth increments by 1. nzcv is not changed by a push.
  - Pop: nzcv <= entry[stack_depth-1]; stack_depth decrements by 1.
  - No wrap-around; the pointer saturates between 0 and DEPTH.
- Priority and boundary cases (pulses are stack_err=1 for the following cycle only):
  - push & pop in the same cycle: neither operation occurs; stack_err pulses; flag capture still follows upd.
  - push when full: dropped, stack_depth unchanged, stack_err pulses.
  - pop when empty: nzcv holds (flag capture is also suppressed that cycle), stack_err pulses.
  - pop (legal) & upd in the same cycle: the restore wins; flags_in is discarded.
  - push & upd in the same cycle: the stack saves the old nzcv and nzcv takes flags_in.
  - stall gates flag capture only; push and pop are still honoured.
- stack_full and stack_empty are combinational from stack_depth.

Test Plan:
- Reset then hold: rst_n low for 2 cycles, flags_in=4'b1111, s_bit=1 -> nzcv=0000, stack_empty=1. Release reset, then one edge with opcode=0000 -> nzcv=1111.
- Capture gating: nzcv=0100. Apply flags_in=1001 with (s_bit=0), then (opcode=1111, s_bit=1), then (stall=1) -> nzcv stays 0100 throughout. Then s_bit=1, opcode=0001, stall=0 -> nzcv=1001 after 1 edge.
- Conditions:
  - nzcv=0110 (Z=1, C=1): EQ=1, NE=0, HI=0, LS=1.
  - nzcv=1001 (N=1, V=1): GE=1, LT=0, GT=1.
  - All states: AL=1, NV=0.
  - BYPASS=1 with upd and flags_in=0100: EQ=1 in the same cycle, before the edge.
- Stack round trip (DEPTH=4): push nzcv values 0001, 0010, 0011, 0100 -> stack_full=1. 5th push -> stack_err pulses, depth stays 4. Four pops restore 0100, 0011, 0010, 0001 in order. 5th pop -> stack_err pulses, nzcv stays 0001.
- Simultaneous events:
  - push+pop with depth=2 -> depth stays 2, stack_err=1.
  - pop+upd with top=1010, flags_in=0101 -> nzcv=1010.
  - push+upd with nzcv=0011, flags_in=1100 -> top=0011, nzcv=1100.
- Asynchronous reset mid-operation: depth=3, then rst_n falls between clock edges -> nzcv=0000 and depth=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/nzcv_status_reg.sv
// Architectural NZCV status register: flag capture, condition-code evaluation
// and a small LIFO of saved flag sets for exception entry/return.
module nzcv_status_reg #(
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 flags_in,
  input  logic                       s_bit,
  input  logic [3:0]                 opcode,
  input  logic                       stall,
  input  logic [3:0]                 cond,
  input  logic                       push,
  input  logic                       pop,
  output logic [3:0]                 nzcv,
  output logic                       cond_pass,
  output logic [$clog2(DEPTH):0]     stack_depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_err
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
    CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
    CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
    CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
  } cc_t;

  logic [3:0]    nzcv_reg;
  logic [3:0]    nzcv_next;
  logic [PW-1:0] depth_reg;
  logic [PW-1:0] depth_next;
  logic          err_reg;
  logic          err_next;
  logic [3:0]    entry_reg [DEPTH];

  logic          upd;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic          pop_bad;
  logic [PW-1:0] depth_dec;
  logic [3:0]    top_entry;
  logic [3:0]    eff;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign upd     = s_bit & (opcode != 4'b1111) & ~stall;
  assign full    = (depth_reg == DEPTH_W);
  assign empty   = (depth_reg == '0);

  // Simultaneous push and pop cancel each other and count as an error.
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign pop_bad = pop & ~push & empty;

  assign depth_dec = depth_reg - PW'(1);
  assign top_entry = entry_reg[depth_dec[AW-1:0]];

  always_comb begin
    err_next = (push & pop) | (push & ~pop & full) | pop_bad;
  end

  always_comb begin
    depth_next = depth_reg;
    if (push_ok) begin
      depth_next = depth_reg + PW'(1);
    end else if (pop_ok) begin
      depth_next = depth_dec;
    end
  end

  // A restore outranks capture; an illegal pop freezes the flags entirely.
  always_comb begin
    nzcv_next = nzcv_reg;
    if (pop_ok) begin
      nzcv_next = top_entry;
    end else if (pop_bad) begin
      nzcv_next = nzcv_reg;
    end else if (upd) begin
      nzcv_next = flags_in;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_reg  <= 4'b0000;
      depth_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      nzcv_reg  <= nzcv_next;
      depth_reg <= depth_next;
      err_reg   <= err_next;
    end
  end

  // Each stack slot captures the pre-update flags when it is the push target.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic wr_en;
      assign wr_en = push_ok & (depth_reg == PW'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg[gi] <= 4'b0000;
        end else if (wr_en) begin
          entry_reg[gi] <= nzcv_reg;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Condition evaluation
  // ---------------------------------------------------------------------------
  generate
    if (BYPASS != 0) begin : g_bypass
      assign eff = upd ? flags_in : nzcv_reg;
    end else begin : g_no_bypass
      assign eff = nzcv_reg;
    end
  endgenerate

  always_comb begin
    logic n_f, z_f, c_f, v_f;
    n_f = eff[3];
    z_f = eff[2];
    c_f = eff[1];
    v_f = eff[0];
    cond_pass = 1'b0;
    case (cc_t'(cond))
      CC_EQ: cond_pass = z_f;
      CC_NE: cond_pass = ~z_f;
      CC_CS: cond_pass = c_f;
      CC_CC: cond_pass = ~c_f;
      CC_MI: cond_pass = n_f;
      CC_PL: cond_pass = ~n_f;
      CC_VS: cond_pass = v_f;
      CC_VC: cond_pass = ~v_f;
      CC_HI: cond_pass = c_f & ~z_f;
      CC_LS: cond_pass = ~c_f | z_f;
      CC_GE: cond_pass = (n_f == v_f);
      CC_LT: cond_pass = (n_f != v_f);
      CC_GT: cond_pass = ~z_f & (n_f == v_f);
      CC_LE: cond_pass = z_f | (n_f != v_f);
      CC_AL: cond_pass = 1'b1;
      CC_NV: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign nzcv        = nzcv_reg;
  assign stack_depth = depth_reg;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_reg;

endmodule

// File: tb/tb_nzcv_status_reg.sv
// Directed bench for nzcv_status_reg (DEPTH=4, BYPASS=1).
module tb_nzcv_status_reg;

  logic       clk;
  logic       rst_n;
  logic [3:0] flags_in;
  logic       s_bit;
  logic [3:0] opcode;
  logic       stall;
  logic [3:0] cond;
  logic       push;
  logic       pop;
  logic [3:0] nzcv;
  logic       cond_pass;
  logic [2:0] stack_depth;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  int vectors;
  int miscompares;

  nzcv_status_reg #(.DEPTH(4), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .s_bit(s_bit),
    .opcode(opcode), .stall(stall), .cond(cond), .push(push), .pop(pop),
    .nzcv(nzcv), .cond_pass(cond_pass), .stack_depth(stack_depth),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic set_flags(input logic [3:0] v);
    flags_in = v; s_bit = 1'b1; opcode = 4'b0000; stall = 1'b0;
    step();
    s_bit = 1'b0;
  endtask

  task automatic do_push();
    push = 1'b1; step(); push = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1; step(); pop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flags_in = 4'b1111; s_bit = 1'b1; opcode = 4'b0000;
    stall = 1'b0; cond = 4'b1110; push = 1'b0; pop = 1'b0;
    step(); step();
    chk4("reset nzcv", nzcv, 4'b0000);
    chk4("reset empty", {3'b0, stack_empty}, 4'd1);
    chk4("reset depth", {1'b0, stack_depth}, 4'd0);
    chk4("reset err", {3'b0, stack_err}, 4'd0);
    rst_n = 1'b1;
    step();
    chk4("first capture", nzcv, 4'b1111);
    s_bit = 1'b0;
  endtask

  task automatic test_capture();
    set_flags(4'b0100);
    flags_in = 4'b1001; s_bit = 1'b0; opcode = 4'b0001;
    step(); chk4("gate s_bit=0", nzcv, 4'b0100);
    s_bit = 1'b1; opcode = 4'b1111;
    step(); chk4("gate opcode=1111", nzcv, 4'b0100);
    opcode = 4'b0001; stall = 1'b1;
    step(); chk4("gate stall", nzcv, 4'b0100);
    stall = 1'b0;
    step(); chk4("capture enabled", nzcv, 4'b1001);
    s_bit = 1'b0;
  endtask

  task automatic chk_cond(input string name, input logic [3:0] c, input logic exp);
    cond = c; #1;
    chk4(name, {3'b0, cond_pass}, {3'b0, exp});
  endtask

  task automatic test_conditions();
    set_flags(4'b0110);
    chk_cond("Z1C1 EQ", 4'b0000, 1'b1);
    chk_cond("Z1C1 NE", 4'b0001, 1'b0);
    chk_cond("Z1C1 CS", 4'b0010, 1'b1);
    chk_cond("Z1C1 MI", 4'b0100, 1'b0);
    chk_cond("Z1C1 HI", 4'b1000, 1'b0);
    chk_cond("Z1C1 LS", 4'b1001, 1'b1);
    set_flags(4'b1001);
    chk_cond("N1V1 GE", 4'b1010, 1'b1);
    chk_cond("N1V1 LT", 4'b1011, 1'b0);
    chk_cond("N1V1 GT", 4'b1100, 1'b1);
    chk_cond("N1V1 LE", 4'b1101, 1'b0);
    chk_cond("N1V1 VS", 4'b0110, 1'b1);
    chk_cond("N1V1 PL", 4'b0101, 1'b0);
    set_flags(4'b1000);
    chk_cond("N1V0 LT", 4'b1011, 1'b1);
    chk_cond("N1V0 GT", 4'b1100, 1'b0);
    for (int v = 0; v < 16; v++) begin
      set_flags(4'(v));
      chk_cond($sformatf("AL nzcv=%0d", v), 4'b1110, 1'b1);
      chk_cond($sformatf("NV nzcv=%0d", v), 4'b1111, 1'b0);
    end
    // Bypass: flags being written this cycle decide cond_pass before the edge.
    set_flags(4'b0000);
    flags_in = 4'b0100; s_bit = 1'b1; opcode = 4'b0011;
    chk_cond("bypass EQ", 4'b0000, 1'b1);
    stall = 1'b1;
    chk_cond("bypass off when stalled", 4'b0000, 1'b0);
    stall = 1'b0; s_bit = 1'b0;
    step();
  endtask

  task automatic test_stack();
    logic [3:0] v;
    for (int i = 1; i <= 4; i++) begin
      v = 4'(i);
      set_flags(v);
      do_push();
      chk4($sformatf("push %0d depth", i), {1'b0, stack_depth}, 4'(i));
    end
    chk4("stack full", {3'b0, stack_full}, 4'd1);
    set_flags(4'b1110);
    push = 1'b1; step(); push = 1'b0;
    chk4("push full err", {3'b0, stack_err}, 4'd1);
    chk4("push full depth", {1'b0, stack_depth}, 4'd4);
    step();
    chk4("err one cycle", {3'b0, stack_err}, 4'd0);
    for (int i = 4; i >= 1; i--) begin
      do_pop();
      chk4($sformatf("pop restore %0d", i), nzcv, 4'(i));
    end
    chk4("stack empty", {3'b0, stack_empty}, 4'd1);
    flags_in = 4'b1111; s_bit = 1'b1; opcode = 4'b0000;
    pop = 1'b1; step(); pop = 1'b0; s_bit = 1'b0;
    chk4("pop empty err", {3'b0, stack_err}, 4'd1);
    chk4("pop empty nzcv hold", nzcv, 4'b0001);
    chk4("pop empty depth", {1'b0, stack_depth}, 4'd0);
  endtask

  task automatic test_simultaneous();
    set_flags(4'b0011); do_push();
    set_flags(4'b1010); do_push();
    push = 1'b1; pop = 1'b1; step(); push = 1'b0; pop = 1'b0;
    chk4("push+pop depth", {1'b0, stack_depth}, 4'd2);
    chk4("push+pop err", {3'b0, stack_err}, 4'd1);
    chk4("push+pop nzcv", nzcv, 4'b1010);
    flags_in = 4'b0101; s_bit = 1'b1; opcode = 4'b0000;
    pop = 1'b1; step(); pop = 1'b0; s_bit = 1'b0;
    chk4("pop+upd restore wins", nzcv, 4'b1010);
    chk4("pop+upd depth", {1'b0, stack_depth}, 4'd1);
    set_flags(4'b0011);
    flags_in = 4'b1100; s_bit = 1'b1;
    push = 1'b1; step(); push = 1'b0; s_bit = 1'b0;
    chk4("push+upd nzcv", nzcv, 4'b1100);
    chk4("push+upd depth", {1'b0, stack_depth}, 4'd2);
    do_pop();
    chk4("push+upd saved old", nzcv, 4'b0011);
    // Stall gates capture only; the push still happens.
    stall = 1'b1; flags_in = 4'b1111; s_bit = 1'b1;
    push = 1'b1; step(); push = 1'b0; s_bit = 1'b0; stall = 1'b0;
    chk4("stall push depth", {1'b0, stack_depth}, 4'd2);
    chk4("stall push nzcv", nzcv, 4'b0011);
  endtask

  task automatic test_async_reset();
    set_flags(4'b0111); do_push();
    chk4("pre-reset depth", {1'b0, stack_depth}, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async nzcv", nzcv, 4'b0000);
    chk4("async depth", {1'b0, stack_depth}, 4'd0);
    chk4("async empty", {3'b0, stack_empty}, 4'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_pop();
    chk4("entries discarded err", {3'b0, stack_err}, 4'd1);
    chk4("entries discarded nzcv", nzcv, 4'b0000);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_capture();
    test_conditions();
    test_stack();
    test_simultaneous();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
